// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the SoC UART receiver and transmitter.
//   uart_state_e  framing FSM state encoding (idle, start, data, parity, stop)
//   clks_per_bit  system clocks per serial bit, integer-divided from clock and line rate
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO; DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, reset   clock and synchronous active-high reset (empties the FIFO)
//   push         write push_data; accepted when not full, or when full and a pop happens too
//   push_data    WIDTH-bit write data
//   pop          remove the head entry; ignored while empty
//   head         entry at the head of the queue (stale when empty)
//   full, empty  occupancy flags
//   count        exact occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntFull);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the push writes into.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a receive FIFO drained over a valid/ready pop port.
// Build option: define UART_RX_PARITY_EN for 8E1 framing and the extra parity_err output.
// Ports:
//   clk, reset   system clock and synchronous active-high reset
//   uart_rx      asynchronous serial input, idle high
//   rx_data      byte at the FIFO head (0 when empty)
//   rx_valid     FIFO non-empty
//   rx_ready     pop strobe; head removed on an edge where rx_valid & rx_ready
//   rx_count     FIFO occupancy
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: byte completed while FIFO full (byte discarded)
//   parity_err   sticky: even-parity mismatch (UART_RX_PARITY_EN only)
//   clear_err    clears the sticky flags; a new error in the same cycle wins
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          clear_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e StAfterData = StParity;
`else
    localparam uart_state_e StAfterData = StStop;
`endif

    logic            sync1_q;
    logic            sync2_q;
    logic            sync_prev_q;
    uart_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shreg_q;
    logic            push_q;
    logic            frame_err_q;
    logic            overrun_q;
`ifdef UART_RX_PARITY_EN
    logic            parity_ok_q;
    logic            parity_err_q;
`endif

    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_head;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    // Framing FSM with baud counter; every action happens when the counter reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_ok_q  <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            // Assignments further down override this, so a new error beats the clear.
            if (clear_err) begin
                frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            unique case (state_q)
                StIdle: begin
                    if (sync_prev_q && !sync2_q) begin
                        state_q <= StStart;
                        cnt_q   <= HalfLoad;
                    end
                end
                StStart: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else if (!sync2_q) begin
                        state_q   <= StData;
                        cnt_q     <= FullLoad;
                        bit_idx_q <= '0;
                    end else begin
                        state_q <= StIdle;  // glitch shorter than half a bit
                    end
                end
                StData: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        shreg_q   <= {sync2_q, shreg_q[7:1]};  // LSB arrives first
                        bit_idx_q <= bit_idx_q + 3'd1;
                        cnt_q     <= FullLoad;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StAfterData;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        cnt_q       <= FullLoad;
                        state_q     <= StStop;
                        parity_ok_q <= (sync2_q == ^shreg_q);
                        if (sync2_q != ^shreg_q) begin
                            parity_err_q <= 1'b1;
                        end
                    end
                end
`endif
                StStop: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        // Leave at mid-stop-bit so a following start edge is never missed.
                        state_q <= StIdle;
                        if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
                            push_q <= parity_ok_q;
`else
                            push_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Full FIFO implies rx_valid, so rx_ready alone means the pop makes room.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (push_q && fifo_full && !rx_ready) begin
            overrun_q <= 1'b1;
        end else if (clear_err) begin
            overrun_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (shreg_q),
        .pop       (rx_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_valid  = ~fifo_empty;
    assign rx_data   = fifo_empty ? 8'h00 : fifo_head;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
